// File: rtl/debounce_pkg.sv
// Shared state encoding and counter-width helpers for the button debouncer.
// Imported by the per-channel debouncer and by the multi-channel top level.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'b00,
    PRESS_CHECK   = 2'b01,
    PRESSED       = 2'b10,
    RELEASE_CHECK = 2'b11
  } debounceState_e;

  // Number of bits needed to hold any value 0..maxValue (never less than 1).
  function automatic int counterWidth(input int maxValue);
    return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, stable-level FSM with press/release
// strobes, and an optional hold-to-repeat counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_TIME = 10,
  parameter int HOLD_TIME     = 50,
  parameter int REPEAT_TIME   = 20,
  parameter int REPEAT_ENABLE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_button,
  output logic o_debounced,
  output logic o_pressedPulse,
  output logic o_releasedPulse,
  output logic o_repeatPulse
);

  localparam int               CNT_W   = counterWidth(DEBOUNCE_TIME);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TIME);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  debounceState_e   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_debounced;
  logic             r_pressedPulse;
  logic             r_releasedPulse;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted once the counter has seen DEBOUNCE_TIME+1
  // consecutive matching samples; the strobes register on that same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_debounced     <= 1'b0;
      r_pressedPulse  <= 1'b0;
      r_releasedPulse <= 1'b0;
    end else begin
      r_pressedPulse  <= 1'b0;
      r_releasedPulse <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_debounced <= 1'b0;
          if (r_sync2) begin
            r_state <= PRESS_CHECK;
            r_cnt   <= CNT_ONE;
          end
        end
        PRESS_CHECK: begin
          if (!r_sync2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state        <= PRESSED;
            r_cnt          <= '0;
            r_debounced    <= 1'b1;
            r_pressedPulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          r_debounced <= 1'b1;
          if (!r_sync2) begin
            r_state <= RELEASE_CHECK;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASE_CHECK: begin
          if (r_sync2) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_debounced     <= 1'b0;
            r_releasedPulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_debounced     = r_debounced;
  assign o_pressedPulse  = r_pressedPulse;
  assign o_releasedPulse = r_releasedPulse;

  generate
    if (REPEAT_ENABLE != 0) begin : g_repeat
      localparam int                HOLD_W        = counterWidth(maxOf(HOLD_TIME, REPEAT_TIME));
      localparam logic [HOLD_W-1:0] HOLD_TARGET   = HOLD_W'(HOLD_TIME);
      localparam logic [HOLD_W-1:0] REPEAT_TARGET = HOLD_W'(REPEAT_TIME);
      localparam logic [HOLD_W-1:0] HOLD_ONE      = HOLD_W'(1);

      logic [HOLD_W-1:0] r_holdCnt;
      logic              r_repeating;
      logic              r_repeatPulse;
      logic [HOLD_W-1:0] w_holdNext;
      logic [HOLD_W-1:0] w_holdTarget;
      logic              w_enterPressed;

      assign w_enterPressed = (r_state == PRESS_CHECK) && r_sync2 && (r_cnt == CNT_MAX);
      assign w_holdTarget   = r_repeating ? REPEAT_TARGET : HOLD_TARGET;
      assign w_holdNext     = r_holdCnt + HOLD_ONE;

      // Only edges taken from PRESSED advance the count, so a bounce through
      // RELEASE_CHECK pauses the repeat timing instead of restarting it.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_holdCnt     <= '0;
          r_repeating   <= 1'b0;
          r_repeatPulse <= 1'b0;
        end else begin
          r_repeatPulse <= 1'b0;
          if (w_enterPressed || (r_state == IDLE)) begin
            r_holdCnt   <= '0;
            r_repeating <= 1'b0;
          end else if (r_state == PRESSED) begin
            if (w_holdNext == w_holdTarget) begin
              r_holdCnt     <= '0;
              r_repeating   <= 1'b1;
              r_repeatPulse <= 1'b1;
            end else begin
              r_holdCnt <= w_holdNext;
            end
          end
        end
      end

      assign o_repeatPulse = r_repeatPulse;
    end else begin : g_noRepeat
      assign o_repeatPulse = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multi_button_debouncer.sv
// Debounces NUM_BUTTONS independent raw buttons; each bit gets its own
// debounce_channel with no interaction between channels.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_BUTTONS   = 4,
  parameter int DEBOUNCE_TIME = 10,
  parameter int HOLD_TIME     = 50,
  parameter int REPEAT_TIME   = 20,
  parameter int REPEAT_ENABLE = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] debounced,
  output logic [NUM_BUTTONS-1:0] pressed_pulse,
  output logic [NUM_BUTTONS-1:0] released_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_TIME(DEBOUNCE_TIME),
      .HOLD_TIME    (HOLD_TIME),
      .REPEAT_TIME  (REPEAT_TIME),
      .REPEAT_ENABLE(REPEAT_ENABLE)
    ) u_channel (
      .clock          (clock),
      .reset_n        (reset_n),
      .i_button       (buttons[i]),
      .o_debounced    (debounced[i]),
      .o_pressedPulse (pressed_pulse[i]),
      .o_releasedPulse(released_pulse[i]),
      .o_repeatPulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: a table of pulse widths, directed corner-case
// sequences and random button traffic, all compared against a run-length model.
module tb_multi_button_debouncer;
  localparam int NB = 4;
  localparam int DB = 10;
  localparam int HT = 50;
  localparam int RT = 20;

  typedef struct {
    logic [NB-1:0] mask;
    int            width;
    logic [NB-1:0] expPress;
    logic [NB-1:0] expRel;
    int            expRep;
  } vec_t;

  logic          clock;
  logic          reset_n;
  logic [NB-1:0] buttons;
  logic [NB-1:0] debounced;
  logic [NB-1:0] pressedPulse;
  logic [NB-1:0] releasedPulse;
  logic [NB-1:0] repeatPulse;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] accPress, accRel, accDeb;
  int            accRep;

  vec_t          vecs[8];
  int            rem[NB];
  logic [NB-1:0] lvl;
  int            n, cum, firstRep;
  logic          relSeen, debDropped;

  multi_button_debouncer #(
    .NUM_BUTTONS(NB), .DEBOUNCE_TIME(DB), .HOLD_TIME(HT), .REPEAT_TIME(RT), .REPEAT_ENABLE(1)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .buttons       (buttons),
    .debounced     (debounced),
    .pressed_pulse (pressedPulse),
    .released_pulse(releasedPulse),
    .repeat_pulse  (repeatPulse)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: a level flips after DB+1 consecutive disagreeing samples seen two
  // edges late; repeats fire when the count of settled-pressed edges hits
  // HT, HT+RT, HT+2*RT, ...
  logic [NB-1:0] mPipe1, mPipe2, mLevel, mPress, mRel, mRep;
  int            mRun[NB];
  int            mHeld[NB];
  logic          holding;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mPipe1 = '0; mPipe2 = '0; mLevel = '0; mPress = '0; mRel = '0; mRep = '0;
      for (int i = 0; i < NB; i++) begin
        mRun[i]  = 0;
        mHeld[i] = 0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        mPress[i] = 1'b0;
        mRel[i]   = 1'b0;
        mRep[i]   = 1'b0;
        holding   = mLevel[i] && (mRun[i] == 0);
        if (holding) begin
          mHeld[i]++;
          if (mHeld[i] >= HT && ((mHeld[i] - HT) % RT) == 0) mRep[i] = 1'b1;
        end
        if (mPipe2[i] != mLevel[i]) mRun[i]++;
        else mRun[i] = 0;
        if (mRun[i] == DB + 1) begin
          mLevel[i] = ~mLevel[i];
          mRun[i]   = 0;
          if (mLevel[i]) begin
            mPress[i] = 1'b1;
            mHeld[i]  = 0;
          end else begin
            mRel[i] = 1'b1;
          end
        end
        if (!mLevel[i]) mHeld[i] = 0;
      end
      mPipe2 = mPipe1;
      mPipe1 = buttons;
    end
  end

  task automatic checkOutput(input string name, input logic [NB-1:0] actual, input logic [NB-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic checkOutputInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearAcc();
    accPress = '0; accRel = '0; accDeb = '0; accRep = 0;
  endtask

  // Advances one cycle; outputs are sampled on the falling edge.
  task automatic stepCycle();
    @(negedge clock);
    checkOutput("model.debounced", debounced, mLevel);
    checkOutput("model.pressed", pressedPulse, mPress);
    checkOutput("model.released", releasedPulse, mRel);
    checkOutput("model.repeat", repeatPulse, mRep);
    accPress |= pressedPulse;
    accRel   |= releasedPulse;
    accDeb   |= debounced;
    for (int i = 0; i < NB; i++) if (repeatPulse[i]) accRep++;
  endtask

  // kind: 0 = pressed, 1 = released, 2 = repeat. Returns cycles waited, -1 on timeout.
  task automatic waitPulse(input int kind, input int ch, input int bound, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < bound) begin
      stepCycle();
      cycles++;
      case (kind)
        0:       seen = pressedPulse[ch];
        1:       seen = releasedPulse[ch];
        default: seen = repeatPulse[ch];
      endcase
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait.kind%0d.ch%0d: no pulse, expected one within %0d cycles", kind, ch, bound);
      cycles = -1;
    end
  endtask

  task automatic settle();
    buttons = '0;
    repeat (40) stepCycle();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    clearAcc();
    buttons = v.mask;
    repeat (v.width) stepCycle();
    buttons = '0;
    repeat (40) stepCycle();
    checkOutput($sformatf("vec%0d.pressed", idx), accPress, v.expPress);
    checkOutput($sformatf("vec%0d.released", idx), accRel, v.expRel);
    checkOutputInt($sformatf("vec%0d.repeats", idx), accRep, v.expRep);
    checkOutput($sformatf("vec%0d.endLevel", idx), debounced, '0);
  endtask

  initial begin
    // Raw width W gives W synchronised high samples; a press needs DB+1 of them,
    // and the settled-pressed edge count tops out at W-DB.
    vecs[0] = '{4'b0010,  5, 4'b0000, 4'b0000, 0};
    vecs[1] = '{4'b0001, 10, 4'b0000, 4'b0000, 0};
    vecs[2] = '{4'b0001, 11, 4'b0001, 4'b0001, 0};
    vecs[3] = '{4'b0100, 12, 4'b0100, 4'b0100, 0};
    vecs[4] = '{4'b1001, 20, 4'b1001, 4'b1001, 0};
    vecs[5] = '{4'b1000, 59, 4'b1000, 4'b1000, 0};
    vecs[6] = '{4'b1000, 60, 4'b1000, 4'b1000, 1};
    vecs[7] = '{4'b0100, 90, 4'b0100, 4'b0100, 2};

    reset_n = 1'b0;
    buttons = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset.debounced", debounced, '0);
    checkOutput("reset.pressed", pressedPulse, '0);
    checkOutput("reset.released", releasedPulse, '0);
    checkOutput("reset.repeat", repeatPulse, '0);
    reset_n = 1'b1;
    clearAcc();
    repeat (3) stepCycle();
    checkOutput("resetRelease.quiet", accDeb | accPress | accRel, '0);

    // Press latency on channel 0: debounced rises on edge E0+DB+2.
    buttons = 4'b0001;
    repeat (DB + 2) stepCycle();
    checkOutput("latency.beforeEdge", debounced, 4'b0000);
    stepCycle();
    checkOutput("latency.debounced", debounced, 4'b0001);
    checkOutput("latency.pressed", pressedPulse, 4'b0001);
    stepCycle();
    checkOutput("latency.pressedWidth", pressedPulse, 4'b0000);
    settle();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Chatter on channel 1, 3 cycles high / 3 low.
    clearAcc();
    for (int c = 0; c < 100; c++) begin
      buttons[1] = ((c / 3) % 2) == 0;
      stepCycle();
    end
    checkOutput("chatter.debounced", accDeb, '0);
    checkOutput("chatter.pressed", accPress, '0);
    checkOutputInt("chatter.repeats", accRep, 0);
    settle();

    // Hold-to-repeat on channel 2.
    buttons[2] = 1'b1;
    waitPulse(0, 2, 30, n);
    checkOutputInt("hold.pressLatency", n, DB + 3);
    waitPulse(2, 2, 80, n);
    cum = n;
    checkOutputInt("hold.firstRepeat", cum, HT);
    waitPulse(2, 2, 40, n);
    cum += n;
    checkOutputInt("hold.secondRepeat", cum, HT + RT);
    waitPulse(2, 2, 40, n);
    cum += n;
    checkOutputInt("hold.thirdRepeat", cum, HT + 2 * RT);
    buttons[2] = 1'b0;
    waitPulse(1, 2, 30, n);
    checkOutputInt("hold.releaseLatency", n, DB + 3);
    clearAcc();
    repeat (100) stepCycle();
    checkOutputInt("hold.noRepeatAfterRelease", accRep, 0);
    settle();

    // Channel 3 drops low for 4 raw cycles once 30 hold cycles have elapsed.
    buttons[3] = 1'b1;
    waitPulse(0, 3, 30, n);
    firstRep   = -1;
    relSeen    = 1'b0;
    debDropped = 1'b0;
    for (int k = 1; k <= 100 && firstRep < 0; k++) begin
      buttons[3] = (k >= 31 && k <= 34) ? 1'b0 : 1'b1;
      stepCycle();
      if (releasedPulse[3]) relSeen = 1'b1;
      if (!debounced[3]) debDropped = 1'b1;
      if (repeatPulse[3]) firstRep = k;
    end
    checkOutputInt("bounce.firstRepeat", firstRep, HT + 4);
    checkOutputInt("bounce.released", int'(relSeen), 0);
    checkOutputInt("bounce.debouncedDropped", int'(debDropped), 0);
    settle();

    // Channels 0 and 3 pressed on the same edge.
    buttons = 4'b1001;
    waitPulse(0, 0, 30, n);
    checkOutput("simultaneous.pressed", pressedPulse, 4'b1001);
    stepCycle();
    checkOutput("simultaneous.pressedWidth", pressedPulse, 4'b0000);
    settle();

    // Reset asserted mid-cycle while channel 0 is held.
    buttons = 4'b0001;
    waitPulse(0, 0, 30, n);
    repeat (5) stepCycle();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midReset.debounced", debounced, '0);
    checkOutput("midReset.pressed", pressedPulse, '0);
    checkOutput("midReset.released", releasedPulse, '0);
    checkOutput("midReset.repeat", repeatPulse, '0);
    clearAcc();
    repeat (3) stepCycle();
    reset_n = 1'b1;
    checkOutput("midReset.noRelease", accRel, '0);
    waitPulse(0, 0, 30, n);
    checkOutputInt("midReset.freshPress", n, DB + 3);
    settle();

    // Random traffic: mixes short bounces with long holds on every channel.
    lvl = '0;
    for (int i = 0; i < NB; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = ~lvl[i];
          rem[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(40, 140))
                                              : int'($urandom_range(1, 14));
        end
        rem[i]--;
      end
      buttons = lvl;
      stepCycle();
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
